// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction memory request/response bus
interface fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - sequential instruction fetch with prefetch queue and redirect flush
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  fetch_unit_if.master imem,
  output logic        validD,
  output logic [31:0] instrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  input  logic        StallD,
  input  logic        redirectE,
  input  logic [31:0] redirect_pcE
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   pcf;
  logic [31:0]   rsp_pc;
  logic [CW-1:0] count;
  logic [CW-1:0] inflight;
  logic [CW-1:0] drop;
  logic [PW-1:0] rptr;
  logic [PW-1:0] wptr;
  logic [31:0]   instr_q [DEPTH];
  logic [31:0]   pc_q    [DEPTH];

  logic [CW:0]   used;
  logic [CW-1:0] inflight_rsp;
  logic [31:0]   target;
  logic          fire;
  logic          push;
  logic          pop;

  // Credit covers both queued and in-flight words so a response always has a slot.
  assign used                = {1'b0, count} + {1'b0, inflight};
  assign imem.imem_req_valid = reset && !redirectE && (used < (CW+1)'(DEPTH));
  assign imem.imem_req_addr  = pcf;

  assign fire         = imem.imem_req_valid && imem.imem_req_ready;
  assign push         = imem.imem_rsp_valid && (drop == '0);
  assign pop          = validD && !StallD;
  assign target       = redirect_pcE & 32'hFFFF_FFFC;
  assign inflight_rsp = inflight - CW'(imem.imem_rsp_valid);

  assign validD   = (count != '0);
  assign instrD   = validD ? instr_q[rptr] : NOP;
  assign PCD      = validD ? pc_q[rptr] : 32'h0;
  assign PCPlus4D = validD ? pc_q[rptr] + 32'd4 : 32'h0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcf      <= RESET_PC;
      rsp_pc   <= RESET_PC;
      count    <= '0;
      inflight <= '0;
      drop     <= '0;
      rptr     <= '0;
      wptr     <= '0;
    end else if (redirectE) begin
      // Everything still in flight was fetched down the wrong path.
      pcf      <= target;
      rsp_pc   <= target;
      count    <= '0;
      rptr     <= '0;
      wptr     <= '0;
      inflight <= inflight_rsp;
      drop     <= inflight_rsp;
    end else begin
      if (fire) pcf <= pcf + 32'd4;
      inflight <= inflight_rsp + CW'(fire);
      if (imem.imem_rsp_valid && (drop != '0)) drop <= drop - CW'(1);
      if (push) begin
        wptr   <= wptr + PW'(1);
        rsp_pc <= rsp_pc + 32'd4;
      end
      if (pop) rptr <= rptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !redirectE) begin
      instr_q[wptr] <= imem.imem_rsp_data;
      pc_q[wptr]    <= rsp_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && !redirectE) assert (!(push && count == CW'(DEPTH)));
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized and directed checks of fetch_unit against a queue model
module tb_fetch_unit;
  localparam int DEPTH = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 0;
  logic        reset = 0;
  logic        validD;
  logic [31:0] instrD, PCD, PCPlus4D;
  logic        StallD = 0;
  logic        redirectE = 0;
  logic [31:0] redirect_pcE = 0;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .imem(bus), .validD(validD), .instrD(instrD),
    .PCD(PCD), .PCPlus4D(PCPlus4D), .StallD(StallD), .redirectE(redirectE),
    .redirect_pcE(redirect_pcE)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // Model: program-order PCs waiting for decode, and outstanding memory requests.
  logic [31:0] mq[$];
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  int          drop_m = 0;
  logic [31:0] pcf_m = RESET_PC;

  logic        stall_k = 0, ready_k = 1, redir_k = 0;
  logic [31:0] tgt_k = 0;
  int          lat = 1;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h cyc=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    pend_addr.delete();
    pend_due.delete();
    drop_m = 0;
    pcf_m  = RESET_PC;
  endtask

  // Called at a negedge; drives one cycle, checks outputs, advances the model.
  task automatic step();
    logic        rsp, exp_rv, pop_m, fire_m;
    logic [31:0] rsp_addr;
    rsp      = (pend_addr.size() > 0) && (pend_due[0] <= cyc);
    rsp_addr = rsp ? pend_addr[0] : 32'h0;
    bus.imem_rsp_valid = rsp;
    bus.imem_rsp_data  = rsp ? (rsp_addr >> 2) : 32'hDEAD_BEEF;
    bus.imem_req_ready = ready_k;
    StallD       = stall_k;
    redirectE    = redir_k;
    redirect_pcE = tgt_k;
    #1;
    exp_rv = ((mq.size() + pend_addr.size()) < DEPTH) && !redir_k;
    chk("req_valid", {31'b0, bus.imem_req_valid}, {31'b0, exp_rv});
    if (exp_rv) chk("req_addr", bus.imem_req_addr, pcf_m);
    chk("validD", {31'b0, validD}, {31'b0, mq.size() != 0});
    if (mq.size() != 0) begin
      chk("PCD", PCD, mq[0]);
      chk("instrD", instrD, mq[0] >> 2);
      chk("PCPlus4D", PCPlus4D, mq[0] + 32'd4);
    end else begin
      chk("instrD_empty", instrD, 32'h13);
      chk("PCD_empty", PCD, 32'h0);
      chk("PCPlus4D_empty", PCPlus4D, 32'h0);
    end
    pop_m  = (mq.size() != 0) && !stall_k;
    fire_m = exp_rv && ready_k;
    @(posedge clk);
    if (rsp) begin
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end
    if (redir_k) begin
      mq.delete();
      drop_m = pend_addr.size();
      pcf_m  = tgt_k & 32'hFFFF_FFFC;
    end else begin
      if (pop_m) void'(mq.pop_front());
      if (rsp) begin
        if (drop_m > 0) drop_m--;
        else mq.push_back(rsp_addr);
      end
      if (fire_m) begin
        pend_addr.push_back(pcf_m);
        pend_due.push_back(cyc + lat);
        pcf_m += 32'd4;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    logic found;
    bus.imem_req_ready = 1;
    bus.imem_rsp_valid = 0;
    bus.imem_rsp_data  = 0;
    model_clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_valid", {31'b0, bus.imem_req_valid}, 32'h0);
    chk("rst_validD", {31'b0, validD}, 32'h0);
    chk("rst_instrD", instrD, 32'h13);
    chk("rst_PCD", PCD, 32'h0);
    chk("rst_PCPlus4D", PCPlus4D, 32'h0);
    reset = 1;

    // startup, one per cycle
    repeat (20) step();

    // decode stall fills queue then releases
    stall_k = 1;
    repeat (10) step();
    #1;
    chk("stall_req_blocked", {31'b0, bus.imem_req_valid}, 32'h0);
    chk("stall_full", mq.size(), DEPTH);
    stall_k = 0;
    repeat (10) step();

    // redirect with stale words in flight
    lat = 3;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (pend_addr.size() >= 2) found = 1;
      else step();
    end
    chk("reach_inflight2", {31'b0, found}, 32'h1);
    redir_k = 1; tgt_k = 32'h0000_0103;
    step();
    redir_k = 0;
    repeat (20) step();

    // redirect coinciding with response and pop
    lat = 1;
    repeat (6) step();
    redir_k = 1; tgt_k = 32'h0000_2000;
    step();
    redir_k = 0;
    repeat (10) step();

    // request backpressure
    for (int r = 0; r < 3; r++) begin
      ready_k = 1; step();
      ready_k = 0; step();
      ready_k = 0; step();
      ready_k = 1; step();
    end

    // random traffic
    for (int i = 0; i < 400; i++) begin
      stall_k = ($urandom % 4) == 0;
      ready_k = ($urandom % 3) != 0;
      lat     = 1 + int'($urandom % 4);
      redir_k = ($urandom % 16) == 0;
      tgt_k   = $urandom;
      step();
    end
    redir_k = 0; stall_k = 0; ready_k = 1;
    repeat (10) step();

    // reset mid-stream with three queued and one in flight
    stall_k = 1; lat = 2;
    redir_k = 1; tgt_k = 32'h0000_0400;
    step();
    redir_k = 0;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (mq.size() == 3 && pend_addr.size() == 1) found = 1;
      else step();
    end
    chk("reach_c3_i1", {31'b0, found}, 32'h1);
    #2;
    reset = 0;
    bus.imem_rsp_valid = 0;
    #1;
    chk("midrst_validD", {31'b0, validD}, 32'h0);
    chk("midrst_instrD", instrD, 32'h13);
    chk("midrst_PCD", PCD, 32'h0);
    chk("midrst_PCPlus4D", PCPlus4D, 32'h0);
    chk("midrst_req_valid", {31'b0, bus.imem_req_valid}, 32'h0);
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1;
    stall_k = 0; lat = 1;
    repeat (12) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
